pressure_calc: RTL and testbench
================================

# pressure_calc

Downstream consumer of the mole counter. Samples the current mole count `numMoles` (1..5) together with the temperature and volume settings and computes the displayed gas pressure as P = ((n·T) << SCALE_SHIFT) / V. The divide uses an iterative restoring divider. The result drives the pressure readout and the particle-speed logic. A new computation starts automatically whenever any operand changes.

## Interface
- SCALE_SHIFT, 3, power-of-two gas-constant scale applied to n·T
- OP_W, 3, width of each operand (n, T, V)
- P_W, 8, width of the pressure output
- NUM_W (derived, not overridable), 2·OP_W+SCALE_SHIFT = 9, numerator/divider width

Ports:
- clk  in  1  clock
- Reset_n  in  1  reset, synchronous, active-low
- numMoles  in  OP_W  mole count from the mole datapath, legal 1..5
- temperature  in  OP_W  temperature setting, legal 1..5
- volume  in  OP_W  volume setting, legal 1..5; 0 treated as divide-by-zero
- pressure  out  P_W  registered result
- pValid  out  1  one-cycle pulse, high in the first cycle `pressure` shows a new value
- busy  out  1  high while a computation is in flight (MUL, DIV, DONE)

## Operation
- States: IDLE, MUL, DIV, DONE.
- Shadow registers nS, tS, vS hold the operands used by the last started computation. `pending` is a one-bit restart flag.
- IDLE: moves to MUL if any input differs from its shadow, or if `pending` = 1. On that transition: latch inputs into the shadows and clear `pending`. Otherwise stays in IDLE.
- MUL: numerator ← (nS·tS) << SCALE_SHIFT, NUM_W bits, no overflow possible. Load the divider with divisor vS and iteration count NUM_W. Go to DIV.
- DIV: one restoring iteration per cycle, MSB first. Go to DONE after exactly NUM_W iterations.
- DONE: on the edge leaving DONE:
  - pressure ← quotient saturated to 2^P_W−1.
  - If vS = 0, pressure ← 2^P_W−1 regardless of quotient.
  - pValid ← 1.
  - Next state IDLE.
- pValid deasserts on the following edge unconditionally.
- Input change while busy: the running computation completes with its latched operands. Any input differing from its shadow in MUL/DIV/DONE sets `pending`. IDLE then restarts immediately with the latest inputs. Multiple changes collapse into one restart.
- Out-of-range operands (6, 7) are computed arithmetically without clamping; only saturation applies.

## Timing
- Reset (Reset_n low at an edge):
  - state = IDLE
  - pressure = 0
  - pValid = 0
  - busy = 0
  - shadows = 0
  - pending = 1
- Reset asserted mid-computation abandons it with no pValid. The first computation starts in the first IDLE cycle after Reset_n returns high.
- Latency: if the IDLE→MUL edge is E0, then pressure/pValid update at edge E0+NUM_W+2. With defaults this is E0+11.
- busy is decoded from the state register: high from E0 through the cycle ending at E0+NUM_W+2.
- Back-to-back computations: the IDLE cycle carrying pValid may itself take the IDLE→MUL transition. Minimum spacing between pValid pulses is NUM_W+3 cycles.
- Steady inputs produce no further pValid pulses.

## Structure
- Shared package `ideal_gas_pkg`:
  - state encodings (one-hot, 4 bits, matching the existing control FSM style)
  - SCALE_SHIFT default
  - legal operand range constants (MIN=1, MAX=5)
- Sub-module `pressureDivider`: NUM_W-bit restoring divider.
  - Inputs: load, numerator, divisor.
  - Outputs: quotient, done.
  - Divide-by-zero yields an all-ones quotient.
- The top level holds the FSM, shadows, `pending`, and the saturating output register.

## Test plan
- Release reset with n=1, T=1, V=1 held → busy rises, pressure=8 and pValid pulse exactly 11 edges after the IDLE→MUL edge, then no further pulses.
- n=5, T=5, V=1 → pressure=200. Then V=5 → pressure=40. Then n=3, T=4, V=5 → pressure=19 (96/5 truncated).
- V=0 with n=2, T=3 → pressure=255, single pValid.
- Start n=2, T=2, V=2 (→16). During DIV change n to 3, then to 4 → first result 16 with pValid, then exactly one restart yielding 32 with a second pValid NUM_W+3 cycles later.
- Assert Reset_n low during DIV → pressure=0, pValid never pulses for the abandoned job; after release, result recomputed from the current inputs.
- n=7, T=7, V=1 (out of range) → numerator 392, pressure saturates to 255.

Source files
------------

// File: rtl/ideal_gas_pkg.sv
// Shared definitions for the ideal-gas display datapath: control FSM
// encodings, the default gas-constant scale and the legal operand range.
package ideal_gas_pkg;

  localparam int SCALE_SHIFT_DEF = 3;

  localparam int OPERAND_MIN = 1;
  localparam int OPERAND_MAX = 5;

  // One-hot encoding, same style as the existing control FSMs.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_MUL  = 4'b0010,
    ST_DIV  = 4'b0100,
    ST_DONE = 4'b1000
  } calc_state_e;

endpackage

// File: rtl/pressure_calc_divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// A zero divisor makes every trial subtraction succeed, so the quotient
// naturally comes out all ones.
module pressureDivider
  import ideal_gas_pkg::*;
#(
  parameter int NUM_W = 9
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [NUM_W-1:0] numerator,
  input  logic [NUM_W-1:0] divisor,
  output logic [NUM_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [NUM_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W:0]   trial;

  // Load operands, or run one shift/trial-subtract step while iterations remain.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    trial = {rem_q, quo_q[NUM_W-1]};
    if (load) begin
      rem_d = '0;
      quo_d = numerator;
      dvs_d = divisor;
      cnt_d = CNT_W'(NUM_W);
    end else if (cnt_q != '0) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = NUM_W'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[NUM_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient = quo_q;
  // High in the cycle whose closing edge performs the final iteration, so
  // the controller can leave DIV on exactly that edge.
  assign done     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pressure_calc.sv
// Gas pressure readout: P = ((n*T) << SCALE_SHIFT) / V, saturated to the
// output width. Restarts automatically whenever an operand changes; changes
// that arrive mid-computation collapse into a single follow-up restart.
module pressure_calc
  import ideal_gas_pkg::*;
#(
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int OP_W        = 3,
  parameter int P_W         = 8
) (
  input  logic            clk,
  input  logic            Reset_n,
  input  logic [OP_W-1:0] numMoles,
  input  logic [OP_W-1:0] temperature,
  input  logic [OP_W-1:0] volume,
  output logic [P_W-1:0]  pressure,
  output logic            pValid,
  output logic            busy
);

  localparam int NUM_W = 2 * OP_W + SCALE_SHIFT;

  calc_state_e state_q, state_d;

  logic [OP_W-1:0] n_s_q, n_s_d;
  logic [OP_W-1:0] t_s_q, t_s_d;
  logic [OP_W-1:0] v_s_q, v_s_d;
  logic            pending_q, pending_d;
  logic [P_W-1:0]  pressure_q, pressure_d;
  logic            p_valid_q, p_valid_d;

  logic              inputs_differ;
  logic [2*OP_W-1:0] product;
  logic [NUM_W-1:0]  numerator;
  logic [NUM_W-1:0]  divisor;
  logic [NUM_W-1:0]  quotient;
  logic [31:0]       quotient_ext;
  logic [P_W-1:0]    result_sat;
  logic              div_load;
  logic              div_done;

  // Operand comparison, numerator formation and output saturation.
  always_comb begin
    inputs_differ = (numMoles != n_s_q) || (temperature != t_s_q) ||
                    (volume != v_s_q);
    product       = {{OP_W{1'b0}}, n_s_q} * {{OP_W{1'b0}}, t_s_q};
    numerator     = {product, {SCALE_SHIFT{1'b0}}};
    divisor       = {{(NUM_W - OP_W){1'b0}}, v_s_q};
    quotient_ext  = 32'(quotient);
    if (v_s_q == '0) begin
      result_sat = {P_W{1'b1}};
    end else if (quotient_ext > 32'((2 ** P_W) - 1)) begin
      result_sat = {P_W{1'b1}};
    end else begin
      result_sat = P_W'(quotient);
    end
  end

  pressureDivider #(
    .NUM_W(NUM_W)
  ) u_divider (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .load     (div_load),
    .numerator(numerator),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (div_done)
  );

  // Next-state logic: shadow capture, restart flag and result publication.
  always_comb begin
    state_d    = state_q;
    n_s_d      = n_s_q;
    t_s_d      = t_s_q;
    v_s_d      = v_s_q;
    pending_d  = pending_q;
    pressure_d = pressure_q;
    p_valid_d  = 1'b0;
    div_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inputs_differ || pending_q) begin
          n_s_d     = numMoles;
          t_s_d     = temperature;
          v_s_d     = volume;
          pending_d = 1'b0;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        div_load = 1'b1;
        state_d  = ST_DIV;
        if (inputs_differ) pending_d = 1'b1;
      end
      ST_DIV: begin
        if (div_done) state_d = ST_DONE;
        if (inputs_differ) pending_d = 1'b1;
      end
      ST_DONE: begin
        pressure_d = result_sat;
        p_valid_d  = 1'b1;
        state_d    = ST_IDLE;
        if (inputs_differ) pending_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves a restart pending.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      n_s_q      <= '0;
      t_s_q      <= '0;
      v_s_q      <= '0;
      pending_q  <= 1'b1;
      pressure_q <= '0;
      p_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_s_q      <= n_s_d;
      t_s_q      <= t_s_d;
      v_s_q      <= v_s_d;
      pending_q  <= pending_d;
      pressure_q <= pressure_d;
      p_valid_q  <= p_valid_d;
    end
  end

  assign pressure = pressure_q;
  assign pValid   = p_valid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pressure_calc.sv
// Self-checking bench for pressure_calc: a job-level reference model checked
// every cycle, directed scenarios with literal expectations, random stimulus.
module tb_pressure_calc;

  localparam int OP_W        = 3;
  localparam int P_W         = 8;
  localparam int SCALE_SHIFT = 3;
  localparam int NUM_W       = 2 * OP_W + SCALE_SHIFT;
  localparam int LAT         = NUM_W + 2;

  logic            clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic [OP_W-1:0] numMoles = 3'd1;
  logic [OP_W-1:0] temperature = 3'd1;
  logic [OP_W-1:0] volume = 3'd1;
  logic [P_W-1:0]  pressure;
  logic            pValid;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  bit m_ok = 1'b0;
  bit m_inflight, m_pend, m_pv;
  int m_p, m_remaining, m_n, m_t, m_v;

  pressure_calc #(
    .SCALE_SHIFT(SCALE_SHIFT),
    .OP_W       (OP_W),
    .P_W        (P_W)
  ) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .numMoles   (numMoles),
    .temperature(temperature),
    .volume     (volume),
    .pressure   (pressure),
    .pValid     (pValid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int calcPressure(input int n, input int t, input int v);
    int q;
    if (v == 0) return 255;
    q = (n * t * (2 ** SCALE_SHIFT)) / v;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int n, input int t, input int v);
    @(negedge clk);
    numMoles    = OP_W'(n);
    temperature = OP_W'(t);
    volume      = OP_W'(v);
  endtask

  task automatic waitResult(input string name, input int expected,
                            input int max_cycles, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (pValid === 1'b1) begin
        lat = i;
        got = 1'b1;
        checkOutput(name, 32'(pressure), 32'(expected));
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no pValid within %0d cycles, expected pressure %0d",
               name, max_cycles, expected);
    end
  endtask

  task automatic countPulses(input int n_cycles, output int cnt);
    cnt = 0;
    repeat (n_cycles) begin
      @(negedge clk);
      if (pValid === 1'b1) cnt++;
    end
  endtask

  // Job-level reference: each accepted job lands LAT edges after it starts.
  initial forever begin
    bit differ;
    @(posedge clk);
    cycle++;
    differ = (int'(numMoles) != m_n) || (int'(temperature) != m_t) ||
             (int'(volume) != m_v);
    m_pv = 1'b0;
    if (!Reset_n) begin
      m_inflight = 1'b0;
      m_p        = 0;
      m_pend     = 1'b1;
      m_n        = 0;
      m_t        = 0;
      m_v        = 0;
      m_ok       = 1'b1;
    end else if (m_ok) begin
      if (m_inflight) begin
        if (differ) m_pend = 1'b1;
        m_remaining--;
        if (m_remaining == 0) begin
          m_p        = calcPressure(m_n, m_t, m_v);
          m_pv       = 1'b1;
          m_inflight = 1'b0;
        end
      end else if (differ || m_pend) begin
        m_n         = int'(numMoles);
        m_t         = int'(temperature);
        m_v         = int'(volume);
        m_pend      = 1'b0;
        m_inflight  = 1'b1;
        m_remaining = LAT;
      end
    end
  end

  // Every-cycle comparison against the reference, sampled mid-period.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      checkOutput("model_pressure", 32'(pressure), 32'(m_p));
      checkOutput("model_pValid", 32'(pValid), 32'(m_pv));
      checkOutput("model_busy", 32'(busy), 32'(m_inflight));
    end
  end

  initial begin
    int lat, cnt;

    repeat (3) @(negedge clk);
    checkOutput("reset_pressure", 32'(pressure), 32'd0);
    checkOutput("reset_pValid", 32'(pValid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    Reset_n = 1'b1;
    waitResult("first_1_1_1", 8, 20, lat);
    checkOutput("first_latency", 32'(lat), 32'(LAT + 1));
    countPulses(20, cnt);
    checkOutput("steady_no_pulse", 32'(cnt), 32'd0);

    applyStimulus(5, 5, 1);
    waitResult("p_5_5_1", 200, 20, lat);
    checkOutput("latency_5_5_1", 32'(lat), 32'(LAT + 1));
    applyStimulus(5, 5, 5);
    waitResult("p_5_5_5", 40, 20, lat);
    applyStimulus(3, 4, 5);
    waitResult("p_3_4_5", 19, 20, lat);

    applyStimulus(2, 3, 0);
    waitResult("div_by_zero", 255, 20, lat);
    countPulses(20, cnt);
    checkOutput("div_by_zero_single", 32'(cnt), 32'd0);

    applyStimulus(2, 2, 2);
    repeat (4) @(negedge clk);
    numMoles = 3'd3;
    repeat (2) @(negedge clk);
    numMoles = 3'd4;
    waitResult("restart_first", 16, 20, lat);
    waitResult("restart_second", 32, 30, lat);
    checkOutput("restart_spacing", 32'(lat), 32'(NUM_W + 3));
    countPulses(20, cnt);
    checkOutput("restart_once", 32'(cnt), 32'd0);

    applyStimulus(5, 5, 5);
    repeat (5) @(negedge clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midjob_reset_pressure", 32'(pressure), 32'd0);
    checkOutput("midjob_reset_busy", 32'(busy), 32'd0);
    Reset_n = 1'b1;
    waitResult("after_reset", 40, 20, lat);
    checkOutput("after_reset_latency", 32'(lat), 32'(LAT + 1));

    applyStimulus(7, 7, 1);
    waitResult("out_of_range_sat", 255, 20, lat);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        numMoles    = OP_W'($urandom_range(0, 7));
        temperature = OP_W'($urandom_range(0, 7));
        volume      = OP_W'($urandom_range(0, 7));
      end
      Reset_n = ($urandom_range(0, 99) != 0);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
